iomem_word_bridge: RTL

- Sits directly downstream of the cpu top's iomem port and consumes its requests.
- Each request is a 128-bit cache-block transfer: iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata, returning iomem_rdata and iomem_ready.
- Splits each block transfer into up to four 32-bit beats on a word-wide memory port using a req/gnt + rvalid protocol.
- Assembles read words back into a block and returns a single-cycle iomem_ready.

---
 rtl/iomem_word_bridge.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/iomem_word_bridge.sv
// ============================================================================
// iomem_word_bridge
// ----------------------------------------------------------------------------
// Bridges the cpu top's block-wide iomem port onto a 32-bit word memory that
// speaks a req/gnt + rvalid protocol. A block transfer is split into up to
// four word beats, issued strictly one at a time. Read beats are assembled
// back into a block, and the requester sees a single-cycle iomem_ready when
// the whole block is finished.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   iomem_valid    block request valid, held by the master until iomem_ready
//   iomem_ready    one-cycle completion pulse
//   iomem_wstrb    byte strobes for the block; all zero means read
//   iomem_addr     block address; the byte offset within the block is ignored
//   iomem_wdata    write block; word k lives in bits [32k+31:32k]
//   iomem_rdata    last assembled read block, held until the next read ends
//   mem_req_o      beat request to the word memory
//   mem_gnt_i      word memory accepts the beat in this cycle
//   mem_we_o       beat is a write
//   mem_be_o       beat byte enables
//   mem_addr_o     beat byte address (word aligned)
//   mem_wdata_o    beat write data
//   mem_rvalid_i   beat response: read data or write acknowledge
//   mem_rdata_i    beat read data
// ============================================================================
module iomem_word_bridge #(
   parameter int XLEN     = 32,
   parameter int BLK_SIZE = 128
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  iomem_valid,
   output logic                  iomem_ready,
   input  logic [BLK_SIZE/8-1:0] iomem_wstrb,
   input  logic [XLEN-1:0]       iomem_addr,
   input  logic [BLK_SIZE-1:0]   iomem_wdata,
   output logic [BLK_SIZE-1:0]   iomem_rdata,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic                  mem_we_o,
   output logic [3:0]            mem_be_o,
   output logic [XLEN-1:0]       mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_rvalid_i,
   input  logic [31:0]           mem_rdata_i
);

   localparam int WORD_W = 32;
   localparam int NBEATS = BLK_SIZE / WORD_W;
   localparam int BEAT_W = $clog2(NBEATS);
   localparam int STRB_W = BLK_SIZE / 8;
   localparam int OFF_W  = $clog2(BLK_SIZE / 8);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   // Request context captured when the block request is accepted.
   logic [XLEN-1:OFF_W]  addr_q;
   logic [STRB_W-1:0]    wstrb_q;
   logic [BLK_SIZE-1:0]  wdata_q;
   logic                 write_q;
   logic [BEAT_W-1:0]    beat_q;

   // Read data under assembly, and the block presented to the requester.
   logic [BLK_SIZE-1:0]  rbuf_q;
   logic [BLK_SIZE-1:0]  rdata_q;
   logic [BLK_SIZE-1:0]  rbuf_merged;

   // {found, index} of the first beat of a new request and of the beat after
   // the current one.
   logic [BEAT_W:0]      first_sel;
   logic [BEAT_W:0]      next_sel;

   logic                 unused_bits;

   // Returns {found, index} of the lowest beat at or above 'start' that must
   // be issued. Reads issue every beat; writes only beats whose four strobes
   // are not all zero. Scanning downwards lets the lowest match win.
   function automatic logic [BEAT_W:0] find_beat(
      input logic [STRB_W-1:0] strb,
      input logic              wr,
      input int                start
   );
      logic [BEAT_W:0] res;
      res = '0;
      for (int j = NBEATS - 1; j >= 0; j--) begin
         if ((j >= start) && (!wr || (strb[j*4 +: 4] != 4'h0))) begin
            res = {1'b1, BEAT_W'(j)};
         end
      end
      return res;
   endfunction

   // Beat selection and read-word merging. The first beat is chosen from the
   // live request inputs because it is latched in the same edge as the rest
   // of the request; subsequent beats come from the latched strobes. The
   // merged buffer is what the read buffer becomes once the current response
   // word is written in, and is also what gets published on the last beat.
   always_comb begin
      first_sel   = find_beat(iomem_wstrb, |iomem_wstrb, 0);
      next_sel    = find_beat(wstrb_q, write_q, int'(beat_q) + 1);
      rbuf_merged = rbuf_q;
      rbuf_merged[int'(beat_q)*WORD_W +: WORD_W] = mem_rdata_i;
   end

   // The block byte offset is deliberately ignored, and the found flag of the
   // first beat is always set because a write has at least one strobe.
   assign unused_bits = ^{iomem_addr[OFF_W-1:0], first_sel[BEAT_W]};

   // State register. Reset drops any transfer in flight immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Responses are only looked at in ST_WAIT, so an rvalid
   // arriving together with the grant, or a stray one in ST_IDLE after a
   // reset, is dropped. iomem_valid is not looked at in ST_DONE, so a master
   // that still holds valid during the ready cycle does not start a repeat.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (iomem_valid) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_gnt_i) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               state_d = next_sel[BEAT_W] ? ST_REQ : ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request context and read assembly. Everything about the request is
   // captured at acceptance so the master's inputs can wander while busy.
   // On each response the beat index steps to the next beat to issue; on the
   // last response of a read the assembled block is published, so it is
   // already valid in the ready cycle. Writes never touch the published block.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         wstrb_q <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         beat_q  <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
      end else begin
         if ((state_q == ST_IDLE) && iomem_valid) begin
            addr_q  <= iomem_addr[XLEN-1:OFF_W];
            wstrb_q <= iomem_wstrb;
            wdata_q <= iomem_wdata;
            write_q <= |iomem_wstrb;
            rbuf_q  <= '0;
            beat_q  <= first_sel[BEAT_W-1:0];
         end else if ((state_q == ST_WAIT) && mem_rvalid_i) begin
            if (!write_q) begin
               rbuf_q <= rbuf_merged;
            end
            if (next_sel[BEAT_W]) begin
               beat_q <= next_sel[BEAT_W-1:0];
            end else if (!write_q) begin
               rdata_q <= rbuf_merged;
            end
         end
      end
   end

   // Output decode. The beat signals are a pure function of the state and
   // the latched context, so they hold steady for as long as the memory
   // withholds its grant, and read as zero whenever no beat is requested.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'h0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      iomem_ready = 1'b0;
      case (state_q)
         ST_REQ: begin
            mem_req_o   = 1'b1;
            mem_we_o    = write_q;
            mem_be_o    = write_q ? wstrb_q[int'(beat_q)*4 +: 4] : 4'hF;
            mem_addr_o  = {addr_q, beat_q, 2'b00};
            mem_wdata_o = wdata_q[int'(beat_q)*WORD_W +: WORD_W];
         end
         ST_DONE: begin
            iomem_ready = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign iomem_rdata = rdata_q;

endmodule
